// File: rtl/bsg_timeout_timer_pkg.sv
// Shared types for the request-driven timeout timer and its count register.
package bsg_timeout_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } bsg_timeout_timer_state_e;

endpackage

// File: rtl/bsg_counter_set_down.sv
// Loadable down counter; set has priority over decrement, cleared asynchronously by reset_i.
module bsg_counter_set_down
    import bsg_timeout_timer_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               set_i,
    input  logic [width_p-1:0] val_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_r_o
);

    logic [width_p-1:0] count_r;

    // Count register: async clear keeps the count in step with the async-reset FSM.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= {width_p{1'b0}};
        end else if (set_i) begin
            count_r <= val_i;
        end else if (down_i) begin
            count_r <= count_r - width_p'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count_r_o = count_r;

endmodule

// File: rtl/bsg_timeout_timer.sv
// Countdown timer accepting a timeout over valid/ready and pulsing expired_o at zero.
// Optional BSG_TIMEOUT_TIMER_RESTART_EN: accept new requests in RUN to reload the count.
module bsg_timeout_timer
    import bsg_timeout_timer_pkg::*;
#(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] timeout_i,
    output logic               ready_o,
    input  logic               tick_i,
    input  logic               pause_i,
    input  logic               cancel_i,
    output logic               busy_o,
    output logic               expired_o,
    output logic [width_p-1:0] count_o
);

    bsg_timeout_timer_state_e state_r;
    bsg_timeout_timer_state_e state_next_s;

    logic               ready_r;
    logic               busy_r;
    logic               expired_r;
    logic               ready_next_s;

    logic               accept_s;
    logic               cancel_s;
    logic               dec_s;
    logic               timeout_zero_s;
    logic               count_one_s;
    logic               set_s;
    logic [width_p-1:0] val_s;
    logic               down_s;
    logic [width_p-1:0] count_s;

    assign accept_s       = v_i & ready_r;
    assign cancel_s       = cancel_i & (state_r == RUN);
    assign dec_s          = tick_i & ~pause_i;
    assign timeout_zero_s = (timeout_i == {width_p{1'b0}});
    assign count_one_s    = (count_s == width_p'(1));

    // Counter controls: cancel clears and beats a reload; decrement never drives below zero.
    always_comb begin
        set_s  = accept_s | cancel_s;
        val_s  = {width_p{1'b0}};
        down_s = 1'b0;
        if (cancel_s) begin
            val_s = {width_p{1'b0}};
        end else if (accept_s) begin
            val_s = timeout_i;
        end else begin
            val_s = {width_p{1'b0}};
        end
        if ((state_r == RUN) && dec_s && !cancel_i && (count_s != {width_p{1'b0}})) begin
            down_s = 1'b1;
        end else begin
            down_s = 1'b0;
        end
    end

    bsg_counter_set_down #(
        .width_p (width_p)
    ) counter (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .set_i     (set_s),
        .val_i     (val_s),
        .down_i    (down_s),
        .count_r_o (count_s)
    );

    // Next-state logic; in RUN an accept can only occur when reload is enabled.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = timeout_zero_s ? EXPIRE : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cancel_i) begin
                    state_next_s = IDLE;
                end else if (accept_s) begin
                    state_next_s = timeout_zero_s ? EXPIRE : RUN;
                end else if (dec_s && count_one_s) begin
                    state_next_s = EXPIRE;
                end else begin
                    state_next_s = RUN;
                end
            end
            EXPIRE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

`ifdef BSG_TIMEOUT_TIMER_RESTART_EN
    assign ready_next_s = (state_next_s == IDLE) | (state_next_s == RUN);
`else
    assign ready_next_s = (state_next_s == IDLE);
`endif

    // State and decoded status flags registered together so the outputs are glitch-free.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            ready_r   <= ready_next_s;
            busy_r    <= (state_next_s == RUN);
            expired_r <= (state_next_s == EXPIRE);
        end
    end

    assign ready_o   = ready_r;
    assign busy_o    = busy_r;
    assign expired_o = expired_r;
    assign count_o   = count_s;

endmodule

// File: tb/tb_bsg_timeout_timer.sv
// Directed self-checking bench for bsg_timeout_timer (width_p = 64).
module tb_bsg_timeout_timer;

    logic        clk_i;
    logic        reset_i;
    logic        v_i;
    logic [63:0] timeout_i;
    logic        ready_o;
    logic        tick_i;
    logic        pause_i;
    logic        cancel_i;
    logic        busy_o;
    logic        expired_o;
    logic [63:0] count_o;

    int n_checks = 0;
    int n_fail   = 0;

    int tick_v  [11] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0};
    int pause_v [11] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int cnt_v   [11] = '{3, 3, 3, 3, 3, 2, 2, 1, 1, 0, 0};
    int exp_v   [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    bsg_timeout_timer #(.width_p(64)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .v_i       (v_i),
        .timeout_i (timeout_i),
        .ready_o   (ready_o),
        .tick_i    (tick_i),
        .pause_i   (pause_i),
        .cancel_i  (cancel_i),
        .busy_o    (busy_o),
        .expired_o (expired_o),
        .count_o   (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b0; timeout_i = 64'd0;
        tick_i = 1'b0; pause_i = 1'b0; cancel_i = 1'b0;
        cycle();
        cycle();
        n_checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || expired_o !== 1'b0 || count_o !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: ready=%b busy=%b exp=%b count=%h, want 1 0 0 0", ready_o, busy_o, expired_o, count_o);
        end
        reset_i = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        v_i = 1'b1; timeout_i = 64'd5; tick_i = 1'b1;
        cycle();
        v_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept: busy=%b ready=%b, want 1 0", busy_o, ready_o);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (count_o !== 64'(5 - i) || expired_o !== (i == 5)) begin
                n_fail++;
                $display("FAIL basic_count[%0d]: count=%0d exp=%b, want %0d %b", i, count_o, expired_o, 5 - i, (i == 5));
            end
            cycle();
        end
        n_checks++;
        if (ready_o !== 1'b1 || expired_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: ready=%b exp=%b busy=%b, want 1 0 0", ready_o, expired_o, busy_o);
        end
    endtask

    task automatic test_zero();
        v_i = 1'b1; timeout_i = 64'd0; tick_i = 1'b1;
        cycle();
        v_i = 1'b0;
        n_checks++;
        if (expired_o !== 1'b1 || busy_o !== 1'b0 || ready_o !== 1'b0 || count_o !== 64'd0) begin
            n_fail++;
            $display("FAIL zero_expire: exp=%b busy=%b ready=%b count=%h, want 1 0 0 0", expired_o, busy_o, ready_o, count_o);
        end
        cycle();
        n_checks++;
        if (expired_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_after: exp=%b busy=%b ready=%b, want 0 0 1", expired_o, busy_o, ready_o);
        end
    endtask

    task automatic test_pause();
        v_i = 1'b1; timeout_i = 64'd4; tick_i = 1'b0; pause_i = 1'b1;
        cycle();
        v_i = 1'b0;
        n_checks++;
        if (count_o !== 64'd4 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_load: count=%0d busy=%b, want 4 1", count_o, busy_o);
        end
        for (int i = 0; i < 11; i++) begin
            tick_i  = (tick_v[i] != 0);
            pause_i = (pause_v[i] != 0);
            cycle();
            n_checks++;
            if (count_o !== 64'(cnt_v[i]) || expired_o !== (exp_v[i] != 0)) begin
                n_fail++;
                $display("FAIL pause_seq[%0d]: count=%0d exp=%b, want %0d %0d", i, count_o, expired_o, cnt_v[i], exp_v[i]);
            end
        end
        tick_i = 1'b0; pause_i = 1'b0;
    endtask

    task automatic test_cancel();
        v_i = 1'b1; timeout_i = 64'd3; tick_i = 1'b1;
        cycle();
        v_i = 1'b0;
        cycle();
        cycle();
        n_checks++;
        if (count_o !== 64'd1) begin
            n_fail++;
            $display("FAIL cancel_pre: count=%0d, want 1", count_o);
        end
        cancel_i = 1'b1;
        cycle();
        cancel_i = 1'b0;
        n_checks++;
        if (expired_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 64'd0) begin
            n_fail++;
            $display("FAIL cancel_last: exp=%b busy=%b ready=%b count=%h, want 0 0 1 0", expired_o, busy_o, ready_o, count_o);
        end
        cycle();
        n_checks++;
        if (expired_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_nopulse: exp=%b, want 0", expired_o);
        end
        v_i = 1'b1; timeout_i = 64'd1;
        cycle();
        v_i = 1'b0;
        cycle();
        n_checks++;
        if (expired_o !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel_expire_pulse: exp=%b, want 1", expired_o);
        end
        cancel_i = 1'b1;
        cycle();
        cancel_i = 1'b0;
        n_checks++;
        if (expired_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 64'd0) begin
            n_fail++;
            $display("FAIL cancel_in_expire: exp=%b ready=%b count=%h, want 0 1 0", expired_o, ready_o, count_o);
        end
    endtask

    task automatic test_async_reset();
        v_i = 1'b1; timeout_i = 64'h40; tick_i = 1'b1;
        cycle();
        v_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cycle();
        end
        n_checks++;
        if (count_o !== 64'h20 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: count=%h busy=%b, want 20 1", count_o, busy_o);
        end
        #2;
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (count_o !== 64'd0 || busy_o !== 1'b0 || ready_o !== 1'b1 || expired_o !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now: count=%h busy=%b ready=%b exp=%b, want 0 0 1 0", count_o, busy_o, ready_o, expired_o);
        end
        #1;
        reset_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_checks++;
            if (expired_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_after[%0d]: exp=%b busy=%b, want 0 0", i, expired_o, busy_o);
            end
        end
    endtask

    task automatic test_wide();
        v_i = 1'b1; timeout_i = 64'hFFFF_FFFF_FFFF_FFFF; tick_i = 1'b1;
        cycle();
        v_i = 1'b0;
        cycle();
        cycle();
        cycle();
        n_checks++;
        if (count_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++;
            $display("FAIL wide_count: count=%h, want fffffffffffffffc", count_o);
        end
        cancel_i = 1'b1;
        cycle();
        cancel_i = 1'b0;
        n_checks++;
        if (ready_o !== 1'b1 || count_o !== 64'd0) begin
            n_fail++;
            $display("FAIL wide_cancel: ready=%b count=%h, want 1 0", ready_o, count_o);
        end
    endtask

    task automatic test_run_request();
        v_i = 1'b1; timeout_i = 64'd10; tick_i = 1'b1;
        cycle();
        v_i = 1'b0;
        cycle();
        cycle();
        cycle();
        v_i = 1'b1; timeout_i = 64'd2;
        cycle();
        v_i = 1'b0;
`ifdef BSG_TIMEOUT_TIMER_RESTART_EN
        n_checks++;
        if (count_o !== 64'd2 || busy_o !== 1'b1 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_load: count=%0d busy=%b ready=%b, want 2 1 1", count_o, busy_o, ready_o);
        end
        cycle();
        n_checks++;
        if (count_o !== 64'd1 || expired_o !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_mid: count=%0d exp=%b, want 1 0", count_o, expired_o);
        end
        cycle();
        n_checks++;
        if (count_o !== 64'd0 || expired_o !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_expire: count=%0d exp=%b, want 0 1", count_o, expired_o);
        end
        cycle();
`else
        n_checks++;
        if (count_o !== 64'd6 || ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL run_ignore_v: count=%0d ready=%b busy=%b, want 6 0 1", count_o, ready_o, busy_o);
        end
        cancel_i = 1'b1;
        cycle();
        cancel_i = 1'b0;
`endif
        n_checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || count_o !== 64'd0) begin
            n_fail++;
            $display("FAIL run_request_end: ready=%b busy=%b count=%h, want 1 0 0", ready_o, busy_o, count_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_pause();
        test_cancel();
        test_async_reset();
        test_wide();
        test_run_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
